rv32i_fetch_unit: RTL and testbench

Instruction-fetch stage of the rv32i core, directly upstream of the instruction memory. Holds the program counter, drives the byte address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect (which flushes IF/ID), and halt from the execute stage.

---
 rtl/rv32i_fetch_unit_if.sv | 48 ++++
 rtl/rv32i_fetch_unit.sv | 113 +++++++++++
 tb/tb_rv32i_fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_unit_if.sv
// rv32i_fetch_unit_if: bundles the fetch stage's control inputs, the
// instruction-memory port and the IF/ID pipeline register outputs.
// The master modport is the fetch unit; the slave modport is its environment
// (hazard unit, execute stage, instruction memory, decoder).
interface rv32i_fetch_unit_if;
    logic        stall;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic [1:0]  fetch_state;
    logic        fetch_misalign;

    modport master (
        input  stall,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_instr,
        output imem_addr,
        output if_id_valid,
        output if_id_pc,
        output if_id_pc_plus4,
        output if_id_instr,
        output fetch_state,
        output fetch_misalign
    );

    modport slave (
        output stall,
        output halt,
        output redirect_valid,
        output redirect_pc,
        output imem_instr,
        input  imem_addr,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  if_id_instr,
        input  fetch_state,
        input  fetch_misalign
    );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: instruction-fetch stage. Holds the PC, drives it to the
// combinational instruction memory and registers the returned word into IF/ID.
// Event priority: redirect > halt > stall > normal fetch.
// Optional feature macro: RV32I_FETCH_MISALIGN_EN -- when defined, a redirect to
// a non-word-aligned target is kept as-is, flushes IF/ID, enters HALT and sets a
// sticky fetch_misalign flag; when undefined the target is forced word-aligned.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic                clk,
    input logic                rst,
    rv32i_fetch_unit_if.master bus
);

    localparam logic [1:0] StBoot = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHalt = 2'd2;
    localparam logic [1:0] StIll  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        redir_mis;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef RV32I_FETCH_MISALIGN_EN
    assign redir_tgt = bus.redirect_pc;
    assign redir_mis = (bus.redirect_pc[1:0] != 2'b00);
`else
    // Masking (rather than slicing) keeps every redirect bit referenced.
    assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    assign redir_mis = 1'b0;
`endif

    // Next-state logic for the FSM, PC and IF/ID register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;

        if (state_q == StIll) begin
            state_d = StRun;
        end else if (bus.redirect_valid) begin
            // Redirect is accepted in every legal state and always flushes IF/ID.
            pc_d       = redir_tgt;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            misalign_d = redir_mis;
            state_d    = redir_mis ? StHalt : StRun;
        end else begin
            case (state_q)
                StBoot: state_d = StRun;
                StRun: begin
                    if (bus.halt) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = StHalt;
                    end else if (!bus.stall) begin
                        valid_d  = 1'b1;
                        id_pc_d  = pc_q;
                        id_pc4_d = pc_plus4;
                        instr_d  = bus.imem_instr;
                        pc_d     = pc_plus4;
                    end
                end
                default: ; // HALT holds everything and ignores stall
            endcase
        end
    end

    // State registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.if_id_pc       = id_pc_q;
    assign bus.if_id_pc_plus4 = id_pc4_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.fetch_state    = state_q;
    assign bus.fetch_misalign = misalign_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: table-driven directed bench for rv32i_fetch_unit.
// Instruction memory returns word index (addr >> 2) combinationally.
module tb_rv32i_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    rv32i_fetch_unit_if bus ();

    rv32i_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_instr = {2'b00, bus.imem_addr[31:2]};

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ha;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [31:0] einstr;
        logic [1:0]  est;
        logic [31:0] eaddr;
        logic        emis;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] epc4, input logic [31:0] einstr,
                           input logic [1:0] est, input logic [31:0] eaddr, input logic emis);
        chk({tag, " valid"}, {31'd0, bus.if_id_valid}, {31'd0, ev});
        chk({tag, " pc"}, bus.if_id_pc, epc);
        chk({tag, " pc4"}, bus.if_id_pc_plus4, epc4);
        chk({tag, " instr"}, bus.if_id_instr, einstr);
        chk({tag, " state"}, {30'd0, bus.fetch_state}, {30'd0, est});
        chk({tag, " addr"}, bus.imem_addr, eaddr);
        chk({tag, " misalign"}, {31'd0, bus.fetch_misalign}, {31'd0, emis});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            st ha rv rpc            | v  pc          pc4         instr        st addr        mis
        vecs[0]  = '{0, 0, 0, 32'h0,          0, 32'h0,       32'h0,      NOP,         1, 32'h0,      0};
        vecs[1]  = '{0, 0, 0, 32'h0,          1, 32'h0,       32'h4,      32'h0,       1, 32'h4,      0};
        vecs[2]  = '{0, 0, 0, 32'h0,          1, 32'h4,       32'h8,      32'h1,       1, 32'h8,      0};
        vecs[3]  = '{1, 0, 0, 32'h0,          1, 32'h4,       32'h8,      32'h1,       1, 32'h8,      0};
        vecs[4]  = '{1, 0, 0, 32'h0,          1, 32'h4,       32'h8,      32'h1,       1, 32'h8,      0};
        vecs[5]  = '{1, 0, 0, 32'h0,          1, 32'h4,       32'h8,      32'h1,       1, 32'h8,      0};
        vecs[6]  = '{0, 0, 0, 32'h0,          1, 32'h8,       32'hC,      32'h2,       1, 32'hC,      0};
        vecs[7]  = '{0, 1, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[8]  = '{0, 0, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[9]  = '{1, 0, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[10] = '{0, 0, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[11] = '{0, 0, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[12] = '{0, 0, 0, 32'h0,          0, 32'h8,       32'hC,      NOP,         2, 32'hC,      0};
        vecs[13] = '{0, 0, 1, 32'h0,          0, 32'h8,       32'hC,      NOP,         1, 32'h0,      0};
        vecs[14] = '{0, 0, 0, 32'h0,          1, 32'h0,       32'h4,      32'h0,       1, 32'h4,      0};
        vecs[15] = '{1, 0, 1, 32'h40,         0, 32'h0,       32'h4,      NOP,         1, 32'h40,     0};
        vecs[16] = '{0, 0, 0, 32'h0,          1, 32'h40,      32'h44,     32'h10,      1, 32'h44,     0};
        vecs[17] = '{0, 1, 1, 32'hFFFF_FFFC,  0, 32'h40,      32'h44,     NOP,         1, 32'hFFFF_FFFC, 0};
        vecs[18] = '{0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0,    32'h3FFF_FFFF, 1, 32'h0,    0};
        vecs[19] = '{0, 0, 0, 32'h0,          1, 32'h0,       32'h4,      32'h0,       1, 32'h4,      0};
`ifdef RV32I_FETCH_MISALIGN_EN
        vecs[20] = '{0, 0, 1, 32'h42,         0, 32'h0,       32'h4,      NOP,         2, 32'h42,     1};
`else
        vecs[20] = '{0, 0, 1, 32'h42,         0, 32'h0,       32'h4,      NOP,         1, 32'h40,     0};
`endif
        vecs[21] = '{0, 0, 1, 32'h80,         0, 32'h0,       32'h4,      NOP,         1, 32'h80,     0};
        vecs[22] = '{0, 0, 0, 32'h0,          1, 32'h80,      32'h84,     32'h20,      1, 32'h84,     0};

        bus.stall = 1'b0;
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset state, held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 32'h0, NOP, 2'd0, 32'h0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 23; i++) begin
            bus.stall = vecs[i].st;
            bus.halt = vecs[i].ha;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].epc4,
                    vecs[i].einstr, vecs[i].est, vecs[i].eaddr, vecs[i].emis);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        bus.stall = 1'b0;
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 32'h0, NOP, 2'd0, 32'h0, 1'b0);

        // Redirect taken during the BOOT cycle.
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        @(posedge clk);
        #1;
        chk_all("boot_redir", 1'b0, 32'h0, 32'h0, NOP, 2'd1, 32'h100, 1'b0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("boot_redir_fetch", 1'b1, 32'h100, 32'h104, 32'h40, 2'd1, 32'h104, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
